ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, the successor to the single-byte keyboard decoder.
- Synchronises and glitch-filters `kbclk`, then decodes the full 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
- Checks parity and stop bit, and aborts stalled frames with a watchdog.
- Keeps a shift history of the last DEPTH accepted bytes for display logic (hex decoders sit outside this block).

Parameters:
- SYNC_STAGES, 2, synchroniser flops on `kbclk` and `in` (min 2).
- DEB_CYCLES, 8, consecutive stable clk cycles needed before the filtered `kbclk` level changes (min 1).
- DEPTH, 2, number of bytes held in the history (min 1).
- TIMEOUT_CYCLES, 50000, clk cycles without a sample event before a partial frame is aborted.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- kbclk  input  1  raw PS/2 clock from the pin.
- in  input  1  raw PS/2 data from the pin.
- data_out  output  8*DEPTH  byte history; [7:0] is the newest byte.
- byte_valid  output  1  one-cycle pulse when a byte is pushed.
- parity_err  output  1  one-cycle pulse on a parity failure.
- frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout.
- busy  output  1  high while state != IDLE.
- key_release  output  1  see Optional Feature.

Behaviour:
Reset:
- All registered outputs go to 0; data_out = 0; state = IDLE; counters = 0.
- Synchronisers reset to 1 (bus idle high); filtered `kbclk` resets to 1.

Input conditioning:
- `kbclk` and `in` each pass through SYNC_STAGES flops.
- Filtered `kbclk` copies the synchronised level only after DEB_CYCLES consecutive equal cycles that differ from the current filtered value.
- A sample event is one cycle on a filtered 1->0 transition. On that cycle the synchronised `in` is the sampled bit.

FSM (transitions only on sample events, except timeout):
- IDLE: bit=0 -> DATA with bit count 0. bit=1 -> stay in IDLE (spurious).
- DATA: shift the bit into the shift register, LSB first. The count increments; after the 8th bit -> PARITY.
- PARITY: store the bit -> STOP.
- STOP: evaluate, then -> IDLE. Checks in priority order:
  - stop bit = 0 -> frame_err, byte discarded.
  - XOR of 8 data bits and parity bit = 0 -> parity_err, byte discarded.
  - otherwise push the byte: data_out <= {data_out[8*DEPTH-9:0], byte}, and pulse byte_valid.
- Pulses assert on the cycle after the STOP sample event, together with the data_out update.

Timeout:
- The counter clears on every sample event and whenever state = IDLE.
- In non-IDLE states, reaching TIMEOUT_CYCLES-1 forces IDLE, pulses frame_err and discards the partial byte.
- A sample event in the same cycle as a timeout wins; the timeout is ignored.

Other rules:
- History is a pure shift: the oldest byte drops out, and there is no full condition.
- When DEPTH=1, data_out is replaced on each push.
- Reset mid-frame returns the block to IDLE and clears history. The remainder of the interrupted frame is then handled normally: bits arriving in IDLE are ignored unless they are 0.
- A 0 arriving in IDLE restarts framing, and the resulting misframe is caught by the parity, stop-bit or timeout checks.

Optional Feature:
PS2_BREAK_FILTER_EN
- Defined:
  - A valid 0xF0 byte is not pushed and produces no byte_valid.
  - It sets an internal release flag.
  - The next valid byte is pushed with key_release=1 in the same cycle as byte_valid, and the flag then clears.
  - An error frame also clears the flag. Reset clears it.
- Undefined:
  - 0xF0 is pushed like any other byte.
  - key_release is tied to 0.

Test Plan:
1. Send frame 0x1C, parity 0, stop 1 -> byte_valid one pulse; data_out[7:0]=0x1C; no error pulses; busy back to 0.
2. Send 0x1C then 0x5A (parity 1) with DEPTH=2 -> data_out=0x1C5A; then send 0x29 -> data_out=0x5A29.
3. Send 0x1C with parity 1 -> parity_err pulse, no byte_valid, data_out unchanged. Send 0x1C with stop 0 -> frame_err pulse only.
4. Send start plus 4 data bits, hold `kbclk` high for TIMEOUT_CYCLES+10 cycles -> frame_err pulse, busy=0; following frame 0x5A is accepted correctly.
5. Drive `kbclk` low for DEB_CYCLES-1 cycles while idle with in=0 -> no sample event, busy stays 0. Assert rst_n low mid-frame -> all outputs 0 and state IDLE.
6. With PS2_BREAK_FILTER_EN defined, send 0xF0 then 0x1C -> one byte_valid with key_release=1 and data_out[7:0]=0x1C. Without the macro -> two pulses, data_out=0xF01C, key_release=0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a shift history of the
// last DEPTH accepted bytes. The raw kbclk and data pins are synchronised,
// and kbclk is also glitch-filtered. Each 11-bit frame (start, 8 data bits
// LSB first, odd parity, stop) is decoded and checked. Stalled frames are
// aborted by a watchdog.
//
// Optional feature macro: PS2_BREAK_FILTER_EN. When it is defined, a 0xF0
// break code is not pushed. Instead it flags the next valid byte through
// key_release.
//
// Output semantics: byte_valid, parity_err and frame_err are one-cycle
// strobes with no backpressure. data_out changes in the same cycle that
// byte_valid is high, and it is stable at all other times. key_release is
// only meaningful in the cycle that byte_valid is high.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEB_CYCLES     = 8,
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               kbclk,
  input  logic               in,
  output logic [8*DEPTH-1:0] data_out,
  output logic               byte_valid,
  output logic               parity_err,
  output logic               frame_err,
  output logic               busy,
  output logic               key_release,
  output logic [1:0]         dbg_state
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;
  logic [DW-1:0]          deb_cnt;
  logic                   filt_q;
  logic                   filt_d1;
  logic                   sample;
  logic [TW-1:0]          to_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_q;
  logic                   par_q;
  logic [8*DEPTH-1:0]     hist_next;
`ifdef PS2_BREAK_FILTER_EN
  logic                   rel_flag;
`endif

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign sample    = filt_d1 & ~filt_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // History shift: the newest byte enters at [7:0] and the oldest byte drops out.
  generate
    if (DEPTH == 1) begin : g_hist_one
      assign hist_next = shift_q;
    end else begin : g_hist_many
      assign hist_next = {data_out[8*DEPTH-9:0], shift_q};
    end
  endgenerate

  // Pin synchronisers. They reset high because the PS/2 bus idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], kbclk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], in};
    end
  end

  // Glitch filter: follow the synchronised kbclk only after DEB_CYCLES
  // consecutive cycles that disagree with the current filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      filt_q  <= 1'b1;
      filt_d1 <= 1'b1;
    end else begin
      filt_d1 <= filt_q;
      if (clk_s != filt_q) begin
        if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
          filt_q  <= clk_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Watchdog: count idle cycles between sample events while a frame is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (sample || state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Frame FSM with registered strobes. A sample event takes priority over a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      data_out    <= '0;
      byte_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      key_release <= 1'b0;
      rel_flag    <= 1'b0;
`endif
    end else begin
      byte_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      key_release <= 1'b0;
`endif
      if (sample) begin
        case (state)
          IDLE: begin
            if (!dat_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_q <= {dat_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_q <= dat_s;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_s) begin
              frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              rel_flag  <= 1'b0;
`endif
            end else if (!(^{shift_q, par_q})) begin
              parity_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              rel_flag   <= 1'b0;
`endif
            end else begin
`ifdef PS2_BREAK_FILTER_EN
              if (shift_q == 8'hF0) begin
                rel_flag <= 1'b1;
              end else begin
                data_out    <= hist_next;
                byte_valid  <= 1'b1;
                key_release <= rel_flag;
                rel_flag    <= 1'b0;
              end
`else
              data_out   <= hist_next;
              byte_valid <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
        rel_flag  <= 1'b0;
`endif
      end
    end
  end

`ifndef PS2_BREAK_FILTER_EN
  assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed, table-driven bench for ps2_rx_fifo with
// DEPTH=2 and a shortened watchdog timeout.
module tb_ps2_rx_fifo;

  localparam int DEB = 8;
  localparam int TO  = 1000;

  logic        clk;
  logic        rst_n;
  logic        kbclk;
  logic        in;
  logic [15:0] data_out;
  logic        byte_valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;
  logic        key_release;
  logic [1:0]  dbg_state;

  int tests;
  int fails;
  int bv_cnt;
  int pe_cnt;
  int fe_cnt;
  int kr_cnt;
  bit busy_seen;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    int          bv;
    int          pe;
    int          fe;
    logic [15:0] hist;
  } vec_t;

  vec_t vecs[8];

  ps2_rx_fifo #(
    .SYNC_STAGES(2),
    .DEB_CYCLES(DEB),
    .DEPTH(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kbclk(kbclk),
    .in(in),
    .data_out(data_out),
    .byte_valid(byte_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy),
    .key_release(key_release),
    .dbg_state(dbg_state)
  );

  // Clock and cycle budget
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "time limit");
  end

  // Strobe monitor
  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (parity_err) pe_cnt++;
    if (frame_err) fe_cnt++;
    if (byte_valid && key_release) kr_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    bv_cnt = 0;
    pe_cnt = 0;
    fe_cnt = 0;
    kr_cnt = 0;
    busy_seen = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in = b;
    repeat (10) @(negedge clk);
    kbclk = 1'b0;
    repeat (20) @(negedge clk);
    kbclk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    in = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_counts();
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 16'h001C};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 1, 0, 0, 16'h1C5A};
    vecs[2] = '{8'h29, 1'b0, 1'b1, 1, 0, 0, 16'h5A29};
    vecs[3] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 16'h5A29};
    vecs[4] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1, 16'h5A29};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 16'h2900};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 16'h00FF};
    vecs[7] = '{8'h5A, 1'b0, 1'b0, 0, 0, 1, 16'h00FF};

    // Reset state
    rst_n = 1'b0;
    kbclk = 1'b1;
    in    = 1'b1;
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_strobes", {29'b0, byte_valid, parity_err, frame_err}, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table: good frames, history shift, parity and stop errors
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      check($sformatf("v%0d_byte_valid", i), 32'(bv_cnt), 32'(vecs[i].bv));
      check($sformatf("v%0d_parity_err", i), 32'(pe_cnt), 32'(vecs[i].pe));
      check($sformatf("v%0d_frame_err", i), 32'(fe_cnt), 32'(vecs[i].fe));
      check($sformatf("v%0d_data_out", i), 32'(data_out), 32'(vecs[i].hist));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
      check($sformatf("v%0d_key_release", i), 32'(kr_cnt), 32'h0);
    end

    // Break code followed by a make code
    send_frame(8'hF0, 1'b1, 1'b1);
    begin
      int bv_acc;
      bv_acc = bv_cnt;
      send_frame(8'h1C, 1'b0, 1'b1);
      bv_acc += bv_cnt;
`ifdef PS2_BREAK_FILTER_EN
      check("brk_byte_valid", 32'(bv_acc), 32'd1);
      check("brk_key_release", 32'(kr_cnt), 32'd1);
      check("brk_data_out", 32'(data_out), 32'h00FF_1C);
`else
      check("brk_byte_valid", 32'(bv_acc), 32'd2);
      check("brk_key_release", 32'(kr_cnt), 32'd0);
      check("brk_data_out", 32'(data_out), 32'hF01C);
`endif
    end

    // An error frame between the break code and the make code clears the release flag
    begin
      int bv_acc;
      send_frame(8'hF0, 1'b1, 1'b1);
      bv_acc = bv_cnt;
      send_frame(8'h33, 1'b0, 1'b1);
      check("brk_err_parity", 32'(pe_cnt), 32'd1);
      send_frame(8'h29, 1'b0, 1'b1);
      bv_acc += bv_cnt;
      check("brk_err_key_release", 32'(kr_cnt), 32'd0);
      check("brk_err_data_low", 32'(data_out[7:0]), 32'h29);
`ifdef PS2_BREAK_FILTER_EN
      check("brk_err_byte_valid", 32'(bv_acc), 32'd1);
`else
      check("brk_err_byte_valid", 32'(bv_acc), 32'd2);
`endif
    end

    // Watchdog: start bit plus 4 data bits, then the bus stalls
    clear_counts();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    in = 1'b1;
    check("to_busy_mid", 32'(busy), 32'h1);
    repeat (TO + 10) @(negedge clk);
    check("to_frame_err", 32'(fe_cnt), 32'd1);
    check("to_byte_valid", 32'(bv_cnt), 32'd0);
    check("to_busy_after", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("to_next_valid", 32'(bv_cnt), 32'd1);
    check("to_next_data", 32'(data_out), 32'h295A);

    // Glitch shorter than the filter window while idle with data low
    clear_counts();
    in = 1'b0;
    kbclk = 1'b0;
    repeat (DEB - 1) @(negedge clk);
    kbclk = 1'b1;
    repeat (30) @(negedge clk);
    in = 1'b1;
    check("glitch_busy_seen", 32'(busy_seen), 32'h0);
    check("glitch_state", 32'(dbg_state), 32'h0);

    // Reset in the middle of a frame
    clear_counts();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("mid_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    kbclk = 1'b1;
    in = 1'b1;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    check("mid_rst_strobes", {28'b0, byte_valid, parity_err, frame_err, key_release}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1);
    check("mid_after_valid", 32'(bv_cnt), 32'd1);
    check("mid_after_data", 32'(data_out), 32'h0029);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
